surv_ram_ctrl: RTL
==================

Name: surv_ram_ctrl

Overview:
Downstream neighbour of the ACS survivor buffer in the Viterbi decoder.
- Accepts packed survivor words (WD_RAM_DATA bits) from the buffer and writes them into a circular survivor RAM.
- Tracks how many words have not yet been consumed.
- Offers completed traceback windows to the traceback unit through a ready/ack handshake, plus a 1-cycle-latency random read port.

Parameters:
- WD_RAM_DATA, 8, survivor word width; equals 2*N_ACS, taken from params.v.
- AW, 6, RAM address width; DEPTH = 2**AW = 64 words.
- TB_LEN, 16, words per traceback window; must satisfy 1 <= TB_LEN <= DEPTH.

Ports:
- Clock1  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Active  in  1  decoder enable; low performs a synchronous flush.
- WrEn  in  1  survivor word valid, one word per asserted cycle.
- WrData  in  WD_RAM_DATA  survivor word from the buffer (WrittenSurvivors).
- TbReady  out  1  at least one full window is available.
- TbAck  in  1  single-cycle pulse: traceback takes the offered window.
- TbBase  out  AW  address of the newest word of the offered window.
- RdEn  in  1  read strobe.
- RdAddr  in  AW  read address.
- RdData  out  WD_RAM_DATA  read data, valid one cycle after RdEn.
- RdValid  out  1  high the cycle RdData is valid.
- Fill  out  AW+1  count of unconsumed words, 0..DEPTH.
- Overflow  out  1  sticky flag: a write was dropped because the RAM was full.

Behaviour:
- Reset (async, Reset=0) clears:
  - TbReady=0, TbBase=0, RdData=0, RdValid=0, Fill=0, Overflow=0.
  - Write pointer WrPtr=0; state IDLE.
  - RAM contents are not cleared.
- States: IDLE, FILL, READY.
  - IDLE -> FILL when Active=1.
  - FILL -> READY when next Fill >= TB_LEN.
  - READY -> FILL on TbAck when Fill - TB_LEN (+1 if a write occurs in the same cycle) < TB_LEN.
  - READY stays READY on TbAck when the remaining count is still >= TB_LEN.
  - Any state -> IDLE when Active=0.
- Active=0 (synchronous flush):
  - Clears WrPtr, Fill, TbReady and Overflow.
  - Writes and TbAck are ignored that cycle.
  - The read port keeps working.
- Write:
  - Accepted when WrEn=1, Active=1 and Fill < DEPTH.
  - Data goes to RAM[WrPtr]; WrPtr increments modulo DEPTH (wraps 63 -> 0); Fill increments.
  - When Fill == DEPTH, the write is dropped, Overflow is set (sticky), and WrPtr and Fill are unchanged.
- TbReady is registered and equals (state == READY).
- TbBase is the address of the newest word of the oldest unconsumed window: (RdBase + TB_LEN - 1) mod DEPTH.
  - RdBase is an internal tail pointer.
  - On TbAck, RdBase advances by TB_LEN modulo DEPTH and Fill decreases by TB_LEN.
  - TbBase and TbReady update in the same edge.
- TbAck while TbReady=0 is ignored.
- Simultaneous accepted write and TbAck: Fill_next = Fill + 1 - TB_LEN.
  - A write that is dropped because Fill == DEPTH does not become accepted by a same-cycle ack; Fill_next = DEPTH - TB_LEN.
- Read port:
  - RdData = RAM[RdAddr] registered one cycle after RdEn; RdValid follows RdEn by one cycle.
  - RdData holds its value when RdEn=0.
  - A read and a write to the same address in the same cycle return the old data (read-before-write).
- All arithmetic is unsigned. Fill is AW+1 bits wide and never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: SURV_RAM_PARITY_EN.
- When defined:
  - The RAM stores one extra even-parity bit per word, computed on WrData.
  - A check runs on every read and drives an extra output ParErr (1 bit). ParErr is registered with RdData and reset to 0.
- When undefined: no parity bit, no ParErr port; RAM width is exactly WD_RAM_DATA.

Decomposition:
- Shared package/params.v holds WD_RAM_DATA, N_ACS, the AW and TB_LEN defaults, and the state encodings S_IDLE=2'd0, S_FILL=2'd1, S_READY=2'd2.
- One natural sub-module: surv_dpram, a simple dual-port RAM.
  - One write port and one registered read port, read-before-write.
  - Width parameterised so the optional parity bit fits.
- The controller FSM, pointers and counters live in surv_ram_ctrl.

Test Plan:
- Reset then Active=1, write 16 words 0x00..0x0F -> after the 16th edge TbReady=1, TbBase=15, Fill=16.
- Pulse TbAck once -> next cycle TbReady=0, Fill=0, TbBase=31. Then RdEn with RdAddr=5 -> RdData=0x05 and RdValid=1 one cycle later.
- Write 70 words with no ack -> Fill saturates at 64, Overflow=1. RAM[0] still holds the first word, 0x00.
- With Fill=16 and TbReady=1, assert WrEn and TbAck in the same cycle -> Fill=1, state FILL, TbReady=0.
- Wrap test: ack windows continuously while writing 100 words -> WrPtr wraps through 63 -> 0. Reading RdAddr=(99 mod 64)=35 returns word 99.
- Drop Active for 1 cycle mid-fill (Fill=9) -> Fill=0, TbReady=0, Overflow=0, state IDLE. Assert Reset=0 asynchronously mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/surv_ram_ctrl_pkg.sv
// Shared parameters, state encoding and RAM word layout for the survivor RAM controller.
// SURV_RAM_PARITY_EN adds an even-parity bit to every stored word.
package surv_ram_ctrl_pkg;

  localparam int unsigned N_ACS       = 4;
  localparam int unsigned WD_RAM_DATA = 2 * N_ACS;
  localparam int unsigned AW_DEF      = 6;
  localparam int unsigned TB_LEN_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_e;

  // Stored word; the parity bit (when present) sits above the data.
  typedef struct packed {
`ifdef SURV_RAM_PARITY_EN
    logic                   par;
`endif
    logic [WD_RAM_DATA-1:0] data;
  } ram_word_t;

  localparam int unsigned RAM_W = $bits(ram_word_t);

`ifdef SURV_RAM_PARITY_EN
  function automatic logic even_par(input logic [WD_RAM_DATA-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/surv_ram_ctrl_if.sv
// Bus between the survivor RAM controller and its neighbours (buffer, traceback).
// SURV_RAM_PARITY_EN adds the ParErr read-side flag.
interface surv_ram_ctrl_if
  import surv_ram_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
);

  logic                   Active;
  logic                   WrEn;
  logic [WD_RAM_DATA-1:0] WrData;
  logic                   TbReady;
  logic                   TbAck;
  logic [AW-1:0]          TbBase;
  logic                   RdEn;
  logic [AW-1:0]          RdAddr;
  logic [WD_RAM_DATA-1:0] RdData;
  logic                   RdValid;
  logic [AW:0]            Fill;
  logic                   Overflow;
`ifdef SURV_RAM_PARITY_EN
  logic                   ParErr;
`endif

  modport master (
    output Active, WrEn, WrData, TbAck, RdEn, RdAddr,
`ifdef SURV_RAM_PARITY_EN
    input  ParErr,
`endif
    input  TbReady, TbBase, RdData, RdValid, Fill, Overflow
  );

  modport slave (
    input  Active, WrEn, WrData, TbAck, RdEn, RdAddr,
`ifdef SURV_RAM_PARITY_EN
    output ParErr,
`endif
    output TbReady, TbBase, RdData, RdValid, Fill, Overflow
  );

endinterface

// File: rtl/surv_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module surv_dpram #(
  parameter int unsigned AW = 6,
  parameter int unsigned W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata,
  output logic          rvalid
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d;

  // Storage is never reset; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = re;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/surv_ram_ctrl.sv
// Survivor RAM controller: circular write pointer, fill count, traceback window hand-off.
// SURV_RAM_PARITY_EN stores a parity bit per word and reports ParErr on reads.
module surv_ram_ctrl
  import surv_ram_ctrl_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned TB_LEN = TB_LEN_DEF
) (
  input  logic           Clock1,
  input  logic           Reset,
  surv_ram_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned FW    = AW + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_base_q, rd_base_d;
  logic [AW-1:0]   tb_base_q, tb_base_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            ovf_q, ovf_d;
  logic            tb_ready_q, tb_ready_d;
  logic            wr_acc, ack_acc;
  ram_word_t       wword, rword;

  // Next-state, pointer and counter logic; a low Active flushes everything but the read port.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_base_d = rd_base_q;
    fill_d    = fill_q;
    ovf_d     = ovf_q;
    wr_acc    = bus.Active && bus.WrEn && (fill_q < FW'(DEPTH));
    ack_acc   = bus.Active && bus.TbAck && tb_ready_q;

    if (!bus.Active) begin
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      rd_base_d = '0;
      fill_d    = '0;
      ovf_d     = 1'b0;
    end else begin
      if (bus.WrEn && !wr_acc) ovf_d = 1'b1;
      if (wr_acc)  wr_ptr_d  = wr_ptr_q + AW'(1);
      if (ack_acc) rd_base_d = rd_base_q + AW'(TB_LEN);
      fill_d = fill_q + FW'(wr_acc) - (ack_acc ? FW'(TB_LEN) : FW'(0));
      unique case (state_q)
        S_IDLE:  state_d = S_FILL;
        S_FILL:  if (fill_d >= FW'(TB_LEN)) state_d = S_READY;
        S_READY: if (ack_acc && (fill_d < FW'(TB_LEN))) state_d = S_FILL;
        default: state_d = S_IDLE;
      endcase
    end

    tb_ready_d = (state_d == S_READY);
    tb_base_d  = rd_base_d + AW'(TB_LEN - 1);
  end

  always_ff @(posedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_base_q  <= '0;
      tb_base_q  <= '0;
      fill_q     <= '0;
      ovf_q      <= 1'b0;
      tb_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_base_q  <= rd_base_d;
      tb_base_q  <= tb_base_d;
      fill_q     <= fill_d;
      ovf_q      <= ovf_d;
      tb_ready_q <= tb_ready_d;
    end
  end

  always_comb begin
    wword      = '0;
    wword.data = bus.WrData;
`ifdef SURV_RAM_PARITY_EN
    wword.par  = even_par(bus.WrData);
`endif
  end

  surv_dpram #(
    .AW (AW),
    .W  (RAM_W)
  ) u_ram (
    .clk    (Clock1),
    .rst_n  (Reset),
    .we     (wr_acc),
    .waddr  (wr_ptr_q),
    .wdata  (wword),
    .re     (bus.RdEn),
    .raddr  (bus.RdAddr),
    .rdata  (rword),
    .rvalid (bus.RdValid)
  );

  assign bus.TbReady  = tb_ready_q;
  assign bus.TbBase   = tb_base_q;
  assign bus.Fill     = fill_q;
  assign bus.Overflow = ovf_q;
  assign bus.RdData   = rword.data;
`ifdef SURV_RAM_PARITY_EN
  // Read word is already registered; a clean word (data + parity) XORs to zero.
  assign bus.ParErr   = ^rword;
`endif

endmodule
